// File: rtl/product_divider_pkg.sv
// product_divider_pkg: shared state encoding and default widths for the product divider
package product_divider_pkg;
    localparam int NUM_W_D = 48;
    localparam int DEN_W_D = 32;
    localparam int CNT_W = $clog2(NUM_W_D);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/product_divider.sv
// product_divider: sequential radix-2 restoring divider of the multiplier product by a divisor
module product_divider
    import product_divider_pkg::*;
#(
    parameter int NUM_W = NUM_W_D,
    parameter int DEN_W = DEN_W_D
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] in_num,
    input  logic [DEN_W-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] out_quot,
    output logic [DEN_W-1:0] out_rem,
    output logic             out_dbz
);
    localparam int CW = $clog2(NUM_W);
    state_t           r_state, w_next;
    logic [NUM_W-1:0] r_quot;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz;
    logic [DEN_W:0]   w_sh;
    logic [DEN_W-1:0] w_diff;
    logic             w_ge;
    logic             w_last;
    logic             w_acc;
    // the stored remainder is always below den, so its implicit top bit is zero
    assign w_sh   = {r_rem, r_quot[NUM_W-1]};
    assign w_ge   = w_sh >= {1'b0, r_den};
    assign w_diff = w_sh[DEN_W-1:0] - r_den;
    assign w_last = r_cnt == CW'(NUM_W - 1);
    assign w_acc  = r_state == IDLE && in_valid;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    always_comb begin
        w_next = clr ? IDLE :
                 r_state == IDLE ? (in_valid ? (in_den == '0 ? DONE : CALC) : IDLE) :
                 r_state == CALC ? (w_last ? DONE : CALC) :
                 (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_dbz  <= 1'b0;
        end else if (!clr) begin
            if (w_acc) begin
                r_quot <= in_den == '0 ? '1 : in_num;
                r_rem  <= '0;
                r_den  <= in_den;
                r_cnt  <= '0;
                r_dbz  <= in_den == '0;
            end else if (r_state == CALC) begin
                r_rem  <= w_ge ? w_diff : w_sh[DEN_W-1:0];
                r_quot <= {r_quot[NUM_W-2:0], w_ge};
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign out_quot  = r_quot;
    assign out_rem   = r_rem;
    assign out_dbz   = r_dbz;
endmodule

// File: tb/tb_product_divider.sv
// tb_product_divider: randomized scoreboard bench for product_divider against plain / and % arithmetic
module tb_product_divider;
    localparam int NW = 48;
    localparam int DW = 32;
    logic          clk = 0, rstn = 1, clr = 0, in_valid = 0, out_ready = 0;
    logic [NW-1:0] in_num = '0;
    logic [DW-1:0] in_den = '0;
    logic          in_ready, out_valid, out_dbz;
    logic [NW-1:0] out_quot;
    logic [DW-1:0] out_rem;
    typedef struct {
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          z;
    } res_t;
    res_t sb[$];
    res_t mon_e;
    int   tests = 0, fails = 0;

    product_divider dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .out_dbz(out_dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [NW-1:0] n, input logic [DW-1:0] d);
        res_t e;
        e.q = d == 0 ? {NW{1'b1}} : NW'(n / d);
        e.r = d == 0 ? '0 : DW'(n % d);
        e.z = d == 0;
        return e;
    endfunction

    // handshake completes on the next rising edge; sample mid-cycle
    always @(negedge clk)
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_output", 64'(out_valid), 64'(0));
            else begin
                mon_e = sb.pop_front();
                chk("quot", 64'(out_quot), 64'(mon_e.q));
                chk("rem", 64'(out_rem), 64'(mon_e.r));
                chk("dbz", 64'(out_dbz), 64'(mon_e.z));
            end
        end

    task automatic issue(input logic [NW-1:0] n, input logic [DW-1:0] d, input bit push);
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        if (push) sb.push_back(model(n, d));
        in_num = n; in_den = d; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        in_num = {$urandom, $urandom};
        in_den = $urandom;
    endtask

    task automatic do_div(input logic [NW-1:0] n, input logic [DW-1:0] d, input int hold);
        int   lat;
        res_t e;
        e = model(n, d);
        issue(n, d, 1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            chk("in_ready_busy", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), d == 0 ? 64'(0) : 64'(NW));
        repeat (hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_quot", 64'(out_quot), 64'(e.q));
            chk("hold_rem", 64'(out_rem), 64'(e.r));
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_after_hs", 64'(in_ready), 64'(1));
        chk("valid_after_hs", 64'(out_valid), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_quot"}, 64'(out_quot), 64'(0));
        chk({tag, "_rem"}, 64'(out_rem), 64'(0));
        chk({tag, "_dbz"}, 64'(out_dbz), 64'(0));
    endtask

    initial begin
        logic [NW-1:0] n;
        logic [DW-1:0] d;
        #1 rstn = 0;
        #1 check_reset_outputs("reset");
        #10 rstn = 1;
        @(posedge clk); #1;

        do_div(48'd100, 32'd7, 0);
        do_div(48'd5, 32'd9, 0);
        do_div({NW{1'b1}}, 32'd1, 0);
        do_div({NW{1'b1}}, {DW{1'b1}}, 0);
        do_div(48'd1234, 32'd0, 0);
        do_div(48'd100, 32'd7, 10);
        do_div(48'd1234, 32'd0, 3);

        // abort at iteration 20: nothing may be presented
        issue(48'd12345, 32'd77, 0);
        repeat (19) begin @(posedge clk); #1; end
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        chk("clr_idle", 64'(in_ready), 64'(1));
        out_ready = 1;
        repeat (60) begin
            chk("clr_no_valid", 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end
        out_ready = 0;
        // clr wins over an offer in the same cycle
        in_num = 48'd9; in_den = 32'd0; in_valid = 1; clr = 1;
        @(posedge clk); #1;
        in_valid = 0; clr = 0;
        chk("clr_blocks_accept", 64'(out_valid), 64'(0));
        chk("clr_blocks_ready", 64'(in_ready), 64'(1));
        do_div(48'd1000, 32'd10, 0);

        // asynchronous reset mid-calculation
        issue(48'd999999, 32'd13, 0);
        repeat (10) begin @(posedge clk); #1; end
        #3 rstn = 0;
        #1 check_reset_outputs("rst_calc");
        #2 rstn = 1;
        @(posedge clk); #1;
        do_div(48'd777777, 32'd1000, 0);

        // asynchronous reset while holding a result
        issue(48'd42, 32'd0, 0);
        chk("done_before_rst", 64'(out_valid), 64'(1));
        #3 rstn = 0;
        #1 check_reset_outputs("rst_done");
        #2 rstn = 1;
        @(posedge clk); #1;
        do_div(48'd65536, 32'd3, 0);

        for (int i = 0; i < 20; i++) begin
            n = {$urandom, $urandom};
            d = $urandom_range(0, 3) == 0 ? DW'($urandom_range(0, 20)) : DW'($urandom >> $urandom_range(0, 31));
            do_div(n, d, $urandom_range(0, 3));
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
